// File: rtl/fft_pkg.sv
// Shared FFT datapath constants: rounding mode selectors and signed saturation limits.
package fft_pkg;

  localparam int unsigned RND_TRUNC   = 0;
  localparam int unsigned RND_HALF_UP = 1;

  // Largest and smallest two's complement values representable in w bits
  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/twiddle_cmult_if.sv
// Valid/ready sample stream into and out of the twiddle complex multiplier.
interface twiddle_cmult_if #(
  parameter int unsigned DATA_W = 17,
  parameter int unsigned COEF_W = 8
);

  logic                     in_valid;
  logic                     in_ready;
  logic                     in_conj;
  logic signed [DATA_W-1:0] in_ar;
  logic signed [DATA_W-1:0] in_ai;
  logic signed [COEF_W-1:0] in_wr;
  logic signed [COEF_W-1:0] in_wi;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_re;
  logic signed [DATA_W-1:0] out_im;
  logic                     out_sat;

  modport slave (
    input  in_valid, in_conj, in_ar, in_ai, in_wr, in_wi, out_ready,
    output in_ready, out_valid, out_re, out_im, out_sat
  );

  modport master (
    output in_valid, in_conj, in_ar, in_ai, in_wr, in_wi, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_sat
  );

endinterface

// File: rtl/frac_round_sat.sv
// Drops SHIFT fractional bits (floor or round-half-up) and clamps to an OUT_W signed range.
module frac_round_sat
  import fft_pkg::*;
#(
  parameter int unsigned IN_W     = 26,
  parameter int unsigned SHIFT    = 7,
  parameter int unsigned OUT_W    = 17,
  parameter int unsigned RND_MODE = RND_TRUNC
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y_c,
  output logic                    sat_c
);

  // Headroom above the widest product sum keeps the rounding bias from overflowing
  localparam logic signed [IN_W-1:0] HALF = IN_W'(RND_MODE == RND_HALF_UP) << (SHIFT - 1);

  logic signed [IN_W-1:0] biased_c;
  logic signed [IN_W-1:0] scaled_c;
  logic signed [63:0]     wide_c;

  always_comb begin
    biased_c = x + HALF;
    scaled_c = biased_c >>> SHIFT;
    wide_c   = 64'(scaled_c);
    y_c      = OUT_W'(scaled_c);
    sat_c    = 1'b0;
    if (wide_c > sat_max(OUT_W)) begin
      y_c   = OUT_W'(sat_max(OUT_W));
      sat_c = 1'b1;
    end else if (wide_c < sat_min(OUT_W)) begin
      y_c   = OUT_W'(sat_min(OUT_W));
      sat_c = 1'b1;
    end
  end

endmodule

// File: rtl/twiddle_cmult.sv
// Three-stage pipelined complex multiply by a twiddle (or its conjugate) with round and saturate.
module twiddle_cmult
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W   = 17,
  parameter int unsigned COEF_W   = 8,
  parameter int unsigned RND_MODE = RND_TRUNC
) (
  input  logic            clk,
  input  logic            rst,
  twiddle_cmult_if.slave  bus
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned SUM_W  = PROD_W + 1;

  logic                     en_c;
  logic                     v1, v2;
  logic                     conj1, conj2;
  logic signed [DATA_W-1:0] ar1, ai1;
  logic signed [COEF_W-1:0] wr1, wi1;
  logic signed [PROD_W-1:0] p_rr, p_ii, p_ir, p_ri;
  logic signed [SUM_W-1:0]  sum_re_c, sum_im_c;
  logic signed [DATA_W-1:0] re_c, im_c;
  logic                     sat_re_c, sat_im_c;

  // Whole pipeline stalls together when the output register is full and not drained
  assign en_c         = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en_c;

  // S1: input capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      conj1 <= 1'b0;
      ar1   <= '0;
      ai1   <= '0;
      wr1   <= '0;
      wi1   <= '0;
    end else if (en_c) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        conj1 <= bus.in_conj;
        ar1   <= bus.in_ar;
        ai1   <= bus.in_ai;
        wr1   <= bus.in_wr;
        wi1   <= bus.in_wi;
      end
    end
  end

  // S2: four full-width products
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      conj2 <= 1'b0;
      p_rr  <= '0;
      p_ii  <= '0;
      p_ir  <= '0;
      p_ri  <= '0;
    end else if (en_c) begin
      v2 <= v1;
      if (v1) begin
        conj2 <= conj1;
        p_rr  <= PROD_W'(ar1) * PROD_W'(wr1);
        p_ii  <= PROD_W'(ai1) * PROD_W'(wi1);
        p_ir  <= PROD_W'(ai1) * PROD_W'(wr1);
        p_ri  <= PROD_W'(ar1) * PROD_W'(wi1);
      end
    end
  end

  // Conjugating the twiddle flips the sign of every wi term
  always_comb begin
    sum_re_c = SUM_W'(p_rr) - SUM_W'(p_ii);
    sum_im_c = SUM_W'(p_ir) + SUM_W'(p_ri);
    if (conj2) begin
      sum_re_c = SUM_W'(p_rr) + SUM_W'(p_ii);
      sum_im_c = SUM_W'(p_ir) - SUM_W'(p_ri);
    end
  end

  frac_round_sat #(
    .IN_W(SUM_W), .SHIFT(COEF_W - 1), .OUT_W(DATA_W), .RND_MODE(RND_MODE)
  ) u_rs_re (
    .x(sum_re_c), .y_c(re_c), .sat_c(sat_re_c)
  );

  frac_round_sat #(
    .IN_W(SUM_W), .SHIFT(COEF_W - 1), .OUT_W(DATA_W), .RND_MODE(RND_MODE)
  ) u_rs_im (
    .x(sum_im_c), .y_c(im_c), .sat_c(sat_im_c)
  );

  // S3: output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_re    <= '0;
      bus.out_im    <= '0;
      bus.out_sat   <= 1'b0;
    end else if (en_c) begin
      bus.out_valid <= v2;
      bus.out_sat   <= v2 && (sat_re_c || sat_im_c);
      if (v2) begin
        bus.out_re <= re_c;
        bus.out_im <= im_c;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_cmult.sv
// Self-checking bench for twiddle_cmult: directed vectors plus randomized streams against an arithmetic model.
module tb_twiddle_cmult;

  localparam int unsigned DW = 17;
  localparam int unsigned CW = 8;
  localparam logic signed [DW-1:0] A_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [CW-1:0] W_MIN = {1'b1, {(CW-1){1'b0}}};

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic                 sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  twiddle_cmult_if #(.DATA_W(DW), .COEF_W(CW)) bus ();
  twiddle_cmult_if #(.DATA_W(DW), .COEF_W(CW)) bus_r ();

  twiddle_cmult #(.DATA_W(DW), .COEF_W(CW), .RND_MODE(0)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  twiddle_cmult #(.DATA_W(DW), .COEF_W(CW), .RND_MODE(1)) u_dut_r (
    .clk(clk), .rst(rst), .bus(bus_r)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: exact complex product, floor division by 2^(CW-1), then clamp
  function automatic exp_t model(input longint ar, input longint ai, input longint wr,
                                 input longint wi, input logic conj, input bit rnd);
    longint s [2];
    longint d, v, hi, lo;
    exp_t   e;
    d  = longint'(1) <<< (CW - 1);
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -(longint'(1) <<< (DW - 1));
    s[0] = conj ? (ar * wr + ai * wi) : (ar * wr - ai * wi);
    s[1] = conj ? (ai * wr - ar * wi) : (ai * wr + ar * wi);
    e.sat = 1'b0;
    e.re  = '0;
    e.im  = '0;
    for (int k = 0; k < 2; k++) begin
      if (rnd) s[k] = s[k] + d / 2;
      v = s[k] / d;
      if ((s[k] % d) != 0 && s[k] < 0) v = v - 1;
      if (v > hi) begin v = hi; e.sat = 1'b1; end
      if (v < lo) begin v = lo; e.sat = 1'b1; end
      if (k == 0) e.re = DW'(v);
      else        e.im = DW'(v);
    end
    return e;
  endfunction

  task automatic rand_inputs();
    bus.in_ar   = (($urandom % 6) == 0) ? A_MIN : DW'($urandom);
    bus.in_ai   = DW'($urandom);
    bus.in_wr   = (($urandom % 6) == 0) ? W_MIN : CW'($urandom);
    bus.in_wi   = CW'($urandom);
    bus.in_conj = 1'($urandom);
  endtask

  // Pushes one sample into both DUTs and waits (bounded) for the result; lat counts the accept edge as 1
  task automatic send_one(input logic signed [DW-1:0] ar, input logic signed [DW-1:0] ai,
                          input logic signed [CW-1:0] wr, input logic signed [CW-1:0] wi,
                          input logic conj,
                          output logic signed [DW-1:0] re0, output logic signed [DW-1:0] im0,
                          output logic sat0, output logic signed [DW-1:0] re1, output int lat);
    @(negedge clk);
    bus.in_valid  = 1'b1; bus.in_ar   = ar; bus.in_ai   = ai; bus.in_wr   = wr; bus.in_wi   = wi;
    bus.in_conj   = conj; bus.out_ready = 1'b1;
    bus_r.in_valid = 1'b1; bus_r.in_ar = ar; bus_r.in_ai = ai; bus_r.in_wr = wr; bus_r.in_wi = wi;
    bus_r.in_conj  = conj; bus_r.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid   = 1'b0;
    bus_r.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    re0  = bus.out_re;
    im0  = bus.out_im;
    sat0 = bus.out_sat;
    re1  = bus_r.out_re;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #7;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    n_tests++; if (bus.out_re !== '0 || bus.out_im !== '0) begin n_fail++; $display("FAIL reset_data: got %0d,%0d expected 0,0", bus.out_re, bus.out_im); end
    n_tests++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b expected 0", bus.out_sat); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    logic signed [DW-1:0] re0, im0, re1; logic sat0; int lat;
    send_one(17'sd32768, 17'sd0, 8'sd64, 8'sd0, 1'b0, re0, im0, sat0, re1, lat);
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", lat); end
    n_tests++; if (re0 !== 17'sd16384 || im0 !== 17'sd0) begin n_fail++; $display("FAIL basic_value: got %0d,%0d expected 16384,0", re0, im0); end
    n_tests++; if (sat0 !== 1'b0) begin n_fail++; $display("FAIL basic_sat: got %b expected 0", sat0); end
  endtask

  task automatic test_saturation();
    logic signed [DW-1:0] re0, im0, re1; logic sat0; int lat;
    send_one(A_MIN, 17'sd0, W_MIN, 8'sd0, 1'b0, re0, im0, sat0, re1, lat);
    n_tests++; if (re0 !== 17'sd65535 || im0 !== 17'sd0) begin n_fail++; $display("FAIL sat_value: got %0d,%0d expected 65535,0", re0, im0); end
    n_tests++; if (sat0 !== 1'b1) begin n_fail++; $display("FAIL sat_flag: got %b expected 1", sat0); end
  endtask

  task automatic test_conj();
    logic signed [DW-1:0] re0, im0, re1; logic sat0; int lat;
    send_one(17'sd0, 17'sd32768, 8'sd0, 8'sd64, 1'b0, re0, im0, sat0, re1, lat);
    n_tests++; if (re0 !== -17'sd16384 || im0 !== 17'sd0) begin n_fail++; $display("FAIL conj0_value: got %0d,%0d expected -16384,0", re0, im0); end
    send_one(17'sd0, 17'sd32768, 8'sd0, 8'sd64, 1'b1, re0, im0, sat0, re1, lat);
    n_tests++; if (re0 !== 17'sd16384 || im0 !== 17'sd0) begin n_fail++; $display("FAIL conj1_value: got %0d,%0d expected 16384,0", re0, im0); end
  endtask

  task automatic test_rounding();
    logic signed [DW-1:0] re0, im0, re1; logic sat0; int lat;
    send_one(17'sd1, 17'sd0, 8'sd64, 8'sd0, 1'b0, re0, im0, sat0, re1, lat);
    n_tests++; if (re0 !== 17'sd0) begin n_fail++; $display("FAIL round_trunc_pos: got %0d expected 0", re0); end
    n_tests++; if (re1 !== 17'sd1) begin n_fail++; $display("FAIL round_half_up_pos: got %0d expected 1", re1); end
    send_one(-17'sd1, 17'sd0, 8'sd64, 8'sd0, 1'b0, re0, im0, sat0, re1, lat);
    n_tests++; if (re0 !== -17'sd1) begin n_fail++; $display("FAIL round_trunc_neg: got %0d expected -1", re0); end
    n_tests++; if (re1 !== 17'sd0) begin n_fail++; $display("FAIL round_half_up_neg: got %0d expected 0", re1); end
  endtask

  task automatic test_back_to_back();
    exp_t q[$]; exp_t e, held; bit prev_stall; int popped;
    prev_stall = 1'b0; popped = 0; held = '0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      @(negedge clk);
      bus.in_valid = (cyc < 380) && (($urandom % 4) != 0);
      rand_inputs();
      bus.out_ready = (cyc >= 380) || (($urandom % 10) < 7);
      #1;
      if (prev_stall) begin
        n_tests++;
        if ({bus.out_valid, bus.out_re, bus.out_im, bus.out_sat} !== {1'b1, held}) begin
          n_fail++; $display("FAIL rand_hold: got %0d,%0d,%b expected %0d,%0d,%b", bus.out_re, bus.out_im, bus.out_sat, held.re, held.im, held.sat);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_tests++; popped++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra: got unexpected result %0d,%0d expected none", bus.out_re, bus.out_im);
        end else begin
          e = q.pop_front();
          if (bus.out_re !== e.re || bus.out_im !== e.im || bus.out_sat !== e.sat) begin
            n_fail++; $display("FAIL rand_result: got %0d,%0d,%b expected %0d,%0d,%b", bus.out_re, bus.out_im, bus.out_sat, e.re, e.im, e.sat);
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back(model(bus.in_ar, bus.in_ai, bus.in_wr, bus.in_wi, bus.in_conj, 1'b0));
      prev_stall = bus.out_valid && !bus.out_ready;
      held = '{re: bus.out_re, im: bus.out_im, sat: bus.out_sat};
    end
    bus.in_valid = 1'b0;
    n_tests++; if (q.size() != 0 || popped < 100) begin n_fail++; $display("FAIL rand_drain: got %0d left, %0d popped expected 0 left, >=100 popped", q.size(), popped); end
  endtask

  task automatic test_backpressure();
    exp_t q[$]; exp_t e, held; bit prev_stall; int sent, got, stalls;
    prev_stall = 1'b0; sent = 0; got = 0; stalls = 0; held = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      bus.in_valid = (sent < 8);
      rand_inputs();
      bus.out_ready = !(cyc >= 4 && cyc < 9);
      #1;
      if (prev_stall) begin
        n_tests++;
        if ({bus.out_valid, bus.out_re, bus.out_im, bus.out_sat} !== {1'b1, held}) begin
          n_fail++; $display("FAIL bp_hold: got %0d,%0d,%b expected %0d,%0d,%b", bus.out_re, bus.out_im, bus.out_sat, held.re, held.im, held.sat);
        end
      end
      if (bus.out_valid && !bus.out_ready) begin
        n_tests++; stalls++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready); end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_tests++; got++;
        e = (q.size() != 0) ? q.pop_front() : '0;
        if (bus.out_re !== e.re || bus.out_im !== e.im || bus.out_sat !== e.sat) begin
          n_fail++; $display("FAIL bp_result: got %0d,%0d,%b expected %0d,%0d,%b", bus.out_re, bus.out_im, bus.out_sat, e.re, e.im, e.sat);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sent++;
        q.push_back(model(bus.in_ar, bus.in_ai, bus.in_wr, bus.in_wi, bus.in_conj, 1'b0));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      held = '{re: bus.out_re, im: bus.out_im, sat: bus.out_sat};
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n_tests++; if (got != 8 || sent != 8) begin n_fail++; $display("FAIL bp_count: got %0d results of %0d sent expected 8 of 8", got, sent); end
    n_tests++; if (stalls != 5) begin n_fail++; $display("FAIL bp_stalls: got %0d stalled cycles expected 5", stalls); end
  endtask

  task automatic test_reset_mid();
    logic signed [DW-1:0] re0, im0, re1; logic sat0; int lat; bit stale;
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      rand_inputs();
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid: got %b expected 1", bus.out_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0 || bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: got valid=%b sat=%b expected 0,0", bus.out_valid, bus.out_sat); end
    n_tests++; if (bus.out_re !== '0 || bus.out_im !== '0) begin n_fail++; $display("FAIL rstmid_data: got %0d,%0d expected 0,0", bus.out_re, bus.out_im); end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) stale = 1'b1;
    end
    n_tests++; if (stale) begin n_fail++; $display("FAIL rstmid_stale: got a result after reset expected none"); end
    send_one(17'sd32768, 17'sd0, 8'sd64, 8'sd0, 1'b0, re0, im0, sat0, re1, lat);
    n_tests++; if (lat != 3 || re0 !== 17'sd16384) begin n_fail++; $display("FAIL rstmid_after: got lat=%0d re=%0d expected 3,16384", lat, re0); end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_conj = 1'b0; bus.in_ar = '0; bus.in_ai = '0;
    bus.in_wr = '0; bus.in_wi = '0; bus.out_ready = 1'b0;
    bus_r.in_valid = 1'b0; bus_r.in_conj = 1'b0; bus_r.in_ar = '0; bus_r.in_ai = '0;
    bus_r.in_wr = '0; bus_r.in_wi = '0; bus_r.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_saturation();
    test_conj();
    test_rounding();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
